// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared definitions for the WS2812 pixel serializer slice.
//   PIXEL_W            bits per GRB pixel
//   LED_NUM_DEF        default pixels per frame
//   RESET_CYCLES_DEF   default latch-gap length in clocks
//   BIT_CNT_W          width of the in-pixel bit counter
//   state_t            serializer FSM states (S_LATCH only with WS2812_LATCH_EN)
// Configuration macro: WS2812_LATCH_EN
package ws2812_pkg;

    localparam int unsigned PIXEL_W          = 24;
    localparam int unsigned LED_NUM_DEF      = 8;
    localparam int unsigned RESET_CYCLES_DEF = 3000;
    localparam int unsigned BIT_CNT_W        = $clog2(PIXEL_W);

`ifdef WS2812_LATCH_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_t;
`else
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;
`endif

endpackage

// File: rtl/ws2812_gap_timer.sv
// ws2812_gap_timer: counts the low-time gap that latches a WS2812 frame.
//   clk_in    clock
//   rst_n_in  asynchronous active-low reset
//   start_i   begin a gap (ignored while a gap is already running)
//   done_o    high during the last of RESET_CYCLES counted clocks
module ws2812_gap_timer
    import ws2812_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic start_i,
    output logic done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    assign done_o = run_q && (cnt_q == CNT_W'(RESET_CYCLES - 1));

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        if (!run_q) begin
            if (start_i) begin
                run_d = 1'b1;
                cnt_d = '0;
            end
        end else if (done_o) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ws2812_pixel_serializer.sv
// ws2812_pixel_serializer: accepts 24-bit GRB pixels and hands them MSB first
// (G7 first) to a WS2812 bit driver through a valid/ready bit interface.
//   clk_in / rst_n_in                  clock, asynchronous active-low reset
//   pixel_in, pixel_in_valid           pixel stream in
//   pixel_ready_out                    high only in S_IDLE (registered)
//   code_out, code_out_valid           current bit to the driver
//   code_ready_in                      driver accepts a bit
//   frame_done_out                     one-cycle pulse after the latch gap
//   busy_out                           high outside S_IDLE
// Configuration macro: WS2812_LATCH_EN adds the pixel counter, S_LATCH and
// the gap timer; without it every pixel returns to S_IDLE and the upstream
// owns the latch gap.
module ws2812_pixel_serializer
    import ws2812_pkg::*;
#(
    parameter int unsigned LED_NUM      = LED_NUM_DEF,
    parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               pixel_in_valid,
    output logic               pixel_ready_out,
    output logic               code_out,
    output logic               code_out_valid,
    input  logic               code_ready_in,
    output logic               frame_done_out,
    output logic               busy_out
);

    if (LED_NUM < 1 || LED_NUM > 65535 || RESET_CYCLES < 1 || RESET_CYCLES > 65535 ||
        CNT_W < $clog2(LED_NUM) || CNT_W < $clog2(RESET_CYCLES)) begin : g_param_check
        $error("ws2812_pixel_serializer: illegal parameter value");
    end

    state_t               state_q, state_d;
    logic [PIXEL_W-1:0]   shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 pix_ready_q, pix_ready_d;
    logic                 busy_q, busy_d;
    logic                 code_valid_q, code_valid_d;

`ifdef WS2812_LATCH_EN
    logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 gap_start, gap_done;

    // Starting is only meaningful once the driver has finished the last bit;
    // the timer ignores start while it is already counting.
    assign gap_start = (state_q == S_LATCH) && code_ready_in;

    ws2812_gap_timer #(
        .RESET_CYCLES (RESET_CYCLES),
        .CNT_W        (CNT_W)
    ) u_gap_timer (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start_i  (gap_start),
        .done_o   (gap_done)
    );

    assign frame_done_out = frame_done_q;
`else
    assign frame_done_out = 1'b0;
`endif

    assign pixel_ready_out = pix_ready_q;
    assign busy_out        = busy_q;
    assign code_out_valid  = code_valid_q;
    assign code_out        = shreg_q[PIXEL_W-1];

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
`ifdef WS2812_LATCH_EN
        pix_cnt_d    = pix_cnt_q;
        frame_done_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pixel_in_valid) begin
                    shreg_d   = pixel_in;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (code_ready_in) begin
                    shreg_d = {shreg_q[PIXEL_W-2:0], 1'b0};
                    if (bit_cnt_q == BIT_CNT_W'(PIXEL_W - 1)) begin
                        bit_cnt_d = '0;
`ifdef WS2812_LATCH_EN
                        // Counter holds at LED_NUM-1 and is cleared after the gap,
                        // so it never wraps.
                        if (pix_cnt_q == CNT_W'(LED_NUM - 1)) begin
                            state_d = S_LATCH;
                        end else begin
                            pix_cnt_d = pix_cnt_q + CNT_W'(1);
                            state_d   = S_IDLE;
                        end
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
`ifdef WS2812_LATCH_EN
            S_LATCH: begin
                if (gap_done) begin
                    pix_cnt_d    = '0;
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        pix_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        code_valid_d = (state_d == S_SHIFT);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            pix_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            code_valid_q <= 1'b0;
`ifdef WS2812_LATCH_EN
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            pix_ready_q  <= pix_ready_d;
            busy_q       <= busy_d;
            code_valid_q <= code_valid_d;
`ifdef WS2812_LATCH_EN
            pix_cnt_q    <= pix_cnt_d;
            frame_done_q <= frame_done_d;
`endif
        end
    end

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// tb_ws2812_pixel_serializer: directed scenarios plus randomized traffic for
// ws2812_pixel_serializer, checked every cycle against a bit-queue model.
// Follows WS2812_LATCH_EN the same way the design does.
module tb_ws2812_pixel_serializer;

    localparam int LEDS = 2;
    localparam int GAP  = 20;
`ifdef WS2812_LATCH_EN
    localparam bit LATCH_EN = 1'b1;
`else
    localparam bit LATCH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] pixel_in = '0;
    logic        pixel_in_valid = 1'b0;
    logic        code_ready_in = 1'b0;
    logic        pixel_ready_out, code_out, code_out_valid, frame_done_out, busy_out;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    ws2812_pixel_serializer #(
        .LED_NUM      (LEDS),
        .RESET_CYCLES (GAP),
        .CNT_W        (16)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .pixel_in        (pixel_in),
        .pixel_in_valid  (pixel_in_valid),
        .pixel_ready_out (pixel_ready_out),
        .code_out        (code_out),
        .code_out_valid  (code_out_valid),
        .code_ready_in   (code_ready_in),
        .frame_done_out  (frame_done_out),
        .busy_out        (busy_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 sending bits, 2 waiting for driver idle, 3 gap.
    bit m_bits[$];
    int m_mode = 0;
    int m_pix  = 0;
    int m_gap  = 0;
    bit m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bits.delete();
            m_mode = 0;
            m_pix  = 0;
            m_gap  = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_mode)
                0: if (pixel_in_valid) begin
                    for (int i = 23; i >= 0; i--) m_bits.push_back(pixel_in[i]);
                    m_mode = 1;
                end
                1: if (code_ready_in) begin
                    void'(m_bits.pop_front());
                    if (m_bits.size() == 0) begin
                        if (LATCH_EN && m_pix == LEDS - 1) m_mode = 2;
                        else begin
                            m_pix++;
                            m_mode = 0;
                        end
                    end
                end
                2: if (code_ready_in) begin
                    m_mode = 3;
                    m_gap  = GAP;
                end
                default: begin
                    m_gap--;
                    if (m_gap == 0) begin
                        m_mode = 0;
                        m_pix  = 0;
                        m_done = 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("ready", pixel_ready_out, m_mode == 0);
            check("busy",  busy_out,        m_mode != 0);
            check("valid", code_out_valid,  m_mode == 1);
            check("code",  code_out,        (m_mode == 1) ? m_bits[0] : 1'b0);
            check("done",  frame_done_out,  m_done);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, pixel_ready_out, 1'b1);
        check({tag, "_busy"},  busy_out,        1'b0);
        check({tag, "_valid"}, code_out_valid,  1'b0);
        check({tag, "_code"},  code_out,        1'b0);
        check({tag, "_done"},  frame_done_out,  1'b0);
    endtask

    // Sends one pixel with the driver always ready; called at a negedge with
    // pixel_ready_out high. Returns the 24 bits seen and pixel_ready_out on the
    // last bit cycle and one cycle after the 24th transfer.
    task automatic send_capture(input logic [23:0] px, output logic [23:0] cap,
                                output logic rdy_last, output logic rdy_after);
        pixel_in = px;
        pixel_in_valid = 1'b1;
        code_ready_in = 1'b1;
        @(posedge clk); #1;
        pixel_in_valid = 1'b0;
        pixel_in = 24'($urandom);
        cap = '0;
        rdy_last = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            cap = {cap[22:0], code_out};
            if (i == 23) rdy_last = pixel_ready_out;
        end
        @(negedge clk);
        rdy_after = pixel_ready_out;
    endtask

    initial begin
        logic [23:0] cap;
        logic        rl, ra;
        logic [15:0] tail;
        int ntx, last, smin, smax, lowcnt, done_cnt, rdy_low;
        bit tx;

        // Reset state
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst");
        check_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Single pixel, driver always ready
        send_capture(24'hA50F81, cap, rl, ra);
        check("seq_A50F81", cap, 24'b1010_0101_0000_1111_1000_0001);
        check("ready_last_bit", rl, 1'b0);
        check("ready_after_px0", ra, 1'b1);

        // Bit driver with 6-clock bit period
        pixel_in = 24'h3C_5A_E7;
        pixel_in_valid = 1'b1;
        code_ready_in = 1'b1;
        @(posedge clk); #1;
        pixel_in_valid = 1'b0;
        ntx = 0; last = -1; smin = 1000; smax = 0; lowcnt = 0;
        for (int c = 0; c < 400 && ntx < 24; c++) begin
            @(negedge clk);
            tx = code_out_valid && code_ready_in;
            @(posedge clk); #1;
            if (tx) begin
                ntx++;
                if (last >= 0) begin
                    if (c - last < smin) smin = c - last;
                    if (c - last > smax) smax = c - last;
                end
                last = c;
                code_ready_in = 1'b0;
                lowcnt = 5;
            end else if (lowcnt > 0) begin
                lowcnt--;
                if (lowcnt == 0) code_ready_in = 1'b1;
            end
        end
        check("drv_transfers", ntx, 24);
        check("drv_spacing_min", smin, 6);
        check("drv_spacing_max", smax, 6);
        @(negedge clk);
        check("ready_after_px1", pixel_ready_out, LATCH_EN ? 1'b0 : 1'b1);

        // Frame gap: driver finishes the last bit, then the gap runs
        repeat (5) @(posedge clk);
        #1 code_ready_in = 1'b1;
        done_cnt = 0; rdy_low = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (frame_done_out) done_cnt++;
            if (!pixel_ready_out) rdy_low++;
        end
        check("gap_done_pulses", done_cnt, LATCH_EN ? 1 : 0);
        check("gap_ready_low", rdy_low, LATCH_EN ? GAP + 1 : 0);

        // Stall after 8 bits of 24'hF0C396: bit 15 (=1) must hold
        pixel_in = 24'hF0C396;
        pixel_in_valid = 1'b1;
        code_ready_in = 1'b1;
        @(posedge clk); #1;
        pixel_in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 code_ready_in = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_code", code_out, 1'b1);
            check("stall_valid", code_out_valid, 1'b1);
        end
        @(posedge clk); #1 code_ready_in = 1'b1;
        tail = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            tail = {tail[14:0], code_out};
        end
        check("stall_resume_seq", tail, 16'hC396);
        @(negedge clk);

        // Reset at bit 7 of pixel 1
        pixel_in = 24'h123456;
        pixel_in_valid = 1'b1;
        @(posedge clk); #1;
        pixel_in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        send_capture(24'h00FF01, cap, rl, ra);
        check("post_rst_seq", cap, 24'h00FF01);
        check("post_rst_px0_ready", ra, 1'b1);
        send_capture(24'h8001FE, cap, rl, ra);
        check("post_rst_px1_ready", ra, LATCH_EN ? 1'b0 : 1'b1);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (frame_done_out) done_cnt++;
        end
        check("post_rst_done_pulses", done_cnt, LATCH_EN ? 1 : 0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            pixel_in = 24'($urandom);
            pixel_in_valid = ($urandom_range(0, 3) != 0);
            if (((c / 500) % 2) == 1) code_ready_in = ($urandom_range(0, 5) == 0);
            else                      code_ready_in = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 799) != 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws2812_pixel_serializer.md
WS2812_PIXEL_SERIALIZER -- requirements
Module: ws2812_pixel_serializer

Interface
REQ-001 Parameter: LED_NUM, 8, number of pixels per frame (legal range 1..65535).
REQ-002 Parameter: RESET_CYCLES, 3000, low-time clocks inserted after each frame (60 us at 50 MHz; legal range 1..65535).
REQ-003 Parameter: CNT_W, 16, width of the pixel counter and the gap counter.
REQ-004 Port: clk_in  input  1  clock; all state changes on its rising edge.
REQ-005 Port: rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 Port: pixel_in  input  24  GRB pixel, G[23:16] R[15:8] B[7:0].
REQ-007 Port: pixel_in_valid  input  1  pixel_in is valid.
REQ-008 Port: pixel_ready_out  output  1  serializer can accept a pixel.
REQ-009 Port: code_out  output  1  current bit to the bit driver.
REQ-010 Port: code_out_valid  output  1  code_out is valid.
REQ-011 Port: code_ready_in  input  1  bit driver is idle and accepts a bit.
REQ-012 Port: frame_done_out  output  1  one-cycle pulse when a frame and its latch gap are complete.
REQ-013 Port: busy_out  output  1  high in any state other than S_IDLE.

Function
REQ-014 The FSM SHALL have three states: S_IDLE, S_SHIFT and S_LATCH.
REQ-015 pixel_ready_out SHALL equal (state==S_IDLE); it SHALL have no combinational path from any input.
REQ-016 A pixel transfer SHALL occur on an edge with pixel_in_valid&&pixel_ready_out: shift register<=pixel_in, bit count<=0, state<=S_SHIFT.
REQ-017 code_out_valid SHALL equal (state==S_SHIFT); code_out SHALL equal shift register bit 23 (MSB first, G7 first); the first bit SHALL be valid one cycle after pixel acceptance.
REQ-018 A bit transfer SHALL occur on an edge with code_out_valid&&code_ready_in: shift left by 1, bit count +1.
REQ-019 While code_ready_in is low, code_out and code_out_valid SHALL hold stable indefinitely.
REQ-020 On the 24th bit transfer, the pixel count SHALL increment; state SHALL go to S_LATCH if the count reaches LED_NUM-1 (before the increment) and WS2812_LATCH_EN is defined, otherwise to S_IDLE.
REQ-021 In S_LATCH, the block SHALL first wait for code_ready_in high (last bit finished), then count RESET_CYCLES clocks.
REQ-022 When the gap count ends, the block SHALL clear the pixel count, pulse frame_done_out for exactly one cycle and return to S_IDLE.
REQ-023 pixel_in_valid SHALL be ignored outside S_IDLE; pixel_in SHALL be sampled only at acceptance.
REQ-024 With LED_NUM=1, every pixel SHALL be followed by a latch gap.
REQ-025 Counters SHALL be unsigned CNT_W wide and SHALL never wrap, because they terminate at LED_NUM-1 and RESET_CYCLES-1.

Reset
REQ-026 On rst_n_in low, the block SHALL set state=S_IDLE, shift register=0, all counters=0, code_out=0, code_out_valid=0, frame_done_out=0, busy_out=0 and pixel_ready_out=1.
REQ-027 A reset asserted mid-frame or mid-gap SHALL discard the partial frame, and the first pixel after release SHALL be treated as pixel 0.

Configuration
REQ-028 Macro WS2812_LATCH_EN defined: the pixel counter, S_LATCH and frame_done_out pulses SHALL be present.
REQ-029 Macro WS2812_LATCH_EN undefined: there SHALL be no S_LATCH and no pixel counter, the block SHALL return to S_IDLE after every pixel, frame_done_out SHALL be tied 0, and the upstream owns the gap.

Structure
REQ-030 Package ws2812_pkg SHALL hold the state enum, PIXEL_W=24, and the default LED_NUM and RESET_CYCLES.
REQ-031 The gap counter SHALL be sub-module ws2812_gap_timer (start, done, RESET_CYCLES parameter), instantiated only under WS2812_LATCH_EN.

Verification
REQ-032 Scenario, single pixel: pixel 24'hA5_0F_81 with code_ready_in always 1 -> code_out sequence 1010_0101_0000_1111_1000_0001 on 24 consecutive transfers.
REQ-033 Scenario, with the bit driver attached (3/3 timing): bits are spaced by the driver period, there are no duplicate or dropped bits, and pixel_ready_out rises 1 cycle after the 24th transfer.
REQ-034 Scenario, stall: hold code_ready_in low for 10 cycles mid-pixel -> code_out and code_out_valid stay constant, and the sequence resumes unchanged.
REQ-035 Scenario, frame gap: LED_NUM=2, RESET_CYCLES=20, two pixels -> S_LATCH is entered, 20 cycles counted after the driver goes idle, frame_done_out is high for 1 cycle, and pixel_ready_out is low throughout the gap.
REQ-036 Scenario, reset mid-frame: assert rst_n_in at bit 7 of pixel 1 -> all outputs reach reset values immediately, and the next frame still needs LED_NUM pixels before its gap.
REQ-037 Scenario, macro off: three pixels are back-to-back, there is no gap, and frame_done_out stays 0.
